// File: rtl/wave_key_ctrl.sv
// wave_key_ctrl: turns three debounced key levels into waveform select and
// frequency word updates, with press-and-hold auto-repeat on up/down and a
// one-cycle cfg_valid strobe whenever the stored configuration changes.
module wave_key_ctrl #(
  parameter int FW            = 16,
  parameter int CNT_W         = 25,
  parameter int FREQ_INIT     = 1000,
  parameter int FREQ_MIN      = 10,
  parameter int FREQ_MAX      = 50000,
  parameter int FREQ_STEP     = 10,
  parameter int HOLD_CYCLES   = 25000000,
  parameter int REPEAT_CYCLES = 5000000
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          key_up,
  input  logic          key_down,
  input  logic          key_mode,
  output logic [1:0]    wave_sel,
  output logic [FW-1:0] freq_word,
  output logic          cfg_valid,
  output logic          rep_active
);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT, WAIT_REL} state_t;

  localparam logic [FW-1:0]    F_INIT    = FW'(FREQ_INIT);
  localparam logic [FW-1:0]    F_MIN     = FW'(FREQ_MIN);
  localparam logic [FW-1:0]    F_MAX     = FW'(FREQ_MAX);
  localparam logic [FW-1:0]    F_STEP    = FW'(FREQ_STEP);
  // Saturation thresholds are precomputed so the step never overflows FW bits.
  localparam logic [FW-1:0]    F_UP_LIM  = FW'(FREQ_MAX - FREQ_STEP);
  localparam logic [FW-1:0]    F_DN_LIM  = FW'(FREQ_MIN + FREQ_STEP);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LOAD  = CNT_W'(REPEAT_CYCLES - 1);

  // Key vector bit order: [0] up, [1] down, [2] mode.
  logic [2:0]       keys_in;
  logic [2:0]       k_r_q, k_p_q;
  logic [2:0]       key_rise;
  logic             single_key, accept, mode_hit, step_hit;
  logic             act_held, cnt_zero;
  logic [FW-1:0]    freq_up, freq_dn;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_up_q, dir_up_d;
  logic [1:0]       wave_sel_q, wave_sel_d;
  logic [FW-1:0]    freq_q, freq_d;
  logic             cfg_valid_q, cfg_valid_d;
  logic             rep_active_q, rep_active_d;

  assign keys_in = {key_mode, key_down, key_up};

  // Two-stage key pipeline; reset to ones so a key held through reset shows no edge.
  always_ff @(posedge clk) begin
    if (clr) begin
      k_r_q <= 3'b111;
      k_p_q <= 3'b111;
    end else begin
      k_r_q <= keys_in;
      k_p_q <= k_r_q;
    end
  end

  // Edge/chord decode and saturating step candidates.
  always_comb begin
    key_rise   = k_r_q & ~k_p_q;
    single_key = (k_r_q == 3'b001) || (k_r_q == 3'b010) || (k_r_q == 3'b100);
    accept     = single_key && ((k_r_q & key_rise) != 3'b000);
    mode_hit   = accept && k_r_q[2];
    step_hit   = accept && !k_r_q[2];
    act_held   = dir_up_q ? k_r_q[0] : k_r_q[1];
    cnt_zero   = (cnt_q == '0);
    freq_up    = (freq_q > F_UP_LIM) ? F_MAX : freq_q + F_STEP;
    freq_dn    = (freq_q < F_DN_LIM) ? F_MIN : freq_q - F_STEP;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (clr) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; release of the active key beats counter expiry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (mode_hit)      state_d = WAIT_REL;
        else if (step_hit) state_d = HOLD;
      end
      HOLD: begin
        if (!act_held)     state_d = IDLE;
        else if (cnt_zero) state_d = REPEAT;
      end
      REPEAT: begin
        if (!act_held)     state_d = IDLE;
      end
      WAIT_REL: begin
        if (!k_r_q[2])     state_d = IDLE;
      end
      default:             state_d = IDLE;
    endcase
  end

  // Output/datapath next values: steps, counter reloads and the change strobe.
  always_comb begin
    wave_sel_d = wave_sel_q;
    freq_d     = freq_q;
    cnt_d      = cnt_q;
    dir_up_d   = dir_up_q;
    case (state_q)
      IDLE: begin
        if (mode_hit) begin
          wave_sel_d = wave_sel_q + 2'd1;
        end else if (step_hit) begin
          dir_up_d = k_r_q[0];
          freq_d   = k_r_q[0] ? freq_up : freq_dn;
          cnt_d    = HOLD_LOAD;
        end
      end
      HOLD, REPEAT: begin
        if (act_held) begin
          if (cnt_zero) begin
            freq_d = dir_up_q ? freq_up : freq_dn;
            cnt_d  = REP_LOAD;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: ;
    endcase
    // A step taken at saturation leaves the value alone and must not strobe.
    cfg_valid_d  = (wave_sel_d != wave_sel_q) || (freq_d != freq_q);
    rep_active_d = (state_d == REPEAT);
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (clr) begin
      wave_sel_q   <= 2'd0;
      freq_q       <= F_INIT;
      cnt_q        <= '0;
      dir_up_q     <= 1'b0;
      cfg_valid_q  <= 1'b0;
      rep_active_q <= 1'b0;
    end else begin
      wave_sel_q   <= wave_sel_d;
      freq_q       <= freq_d;
      cnt_q        <= cnt_d;
      dir_up_q     <= dir_up_d;
      cfg_valid_q  <= cfg_valid_d;
      rep_active_q <= rep_active_d;
    end
  end

  assign wave_sel   = wave_sel_q;
  assign freq_word  = freq_q;
  assign cfg_valid  = cfg_valid_q;
  assign rep_active = rep_active_q;

endmodule

// File: tb/tb_wave_key_ctrl.sv
// Testbench for wave_key_ctrl: edge-indexed reference model checked every
// cycle, a table of tap vectors, hand-written timing sequences and random keys.
module tb_wave_key_ctrl;

  localparam int H    = 8;
  localparam int R    = 4;
  localparam int FI   = 100;
  localparam int FMIN = 10;
  localparam int FMAX = 130;
  localparam int FST  = 10;

  logic        clk = 1'b0;
  logic        clr, key_up, key_down, key_mode;
  logic [1:0]  wave_sel;
  logic [15:0] freq_word;
  logic        cfg_valid, rep_active;

  wave_key_ctrl #(
    .FW(16), .CNT_W(8), .FREQ_INIT(FI), .FREQ_MIN(FMIN), .FREQ_MAX(FMAX),
    .FREQ_STEP(FST), .HOLD_CYCLES(H), .REPEAT_CYCLES(R)
  ) dut (
    .clk(clk), .clr(clr), .key_up(key_up), .key_down(key_down), .key_mode(key_mode),
    .wave_sel(wave_sel), .freq_word(freq_word), .cfg_valid(cfg_valid), .rep_active(rep_active)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int t        = 0;
  int pulses   = 0;

  // Reference model: who owns the panel (0 none, 1 up, 2 down, 3 mode) and
  // the edge index of the first step; repeats are scheduled arithmetically.
  int         m_wave, m_freq, m_busy, m_s;
  bit         m_cfg, m_rep;
  logic [2:0] m_k1, m_k2;

  typedef struct {
    logic [2:0] keys;
    int on_c;
    int off_c;
    int wave;
    int freq;
    int npulse;
  } vec_t;
  vec_t tbl[11];

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, t, act, exp);
    end
  endtask

  task automatic apply_step();
    if (m_busy == 1) m_freq = (m_freq + FST > FMAX) ? FMAX : m_freq + FST;
    else             m_freq = (m_freq - FST < FMIN) ? FMIN : m_freq - FST;
  endtask

  task automatic model_edge();
    logic [2:0] k, p;
    int of, ow;
    k = m_k1;
    p = m_k2;
    t++;
    if (clr) begin
      m_wave = 0; m_freq = FI; m_cfg = 0; m_rep = 0; m_busy = 0;
      m_k1 = 3'b111; m_k2 = 3'b111;
      return;
    end
    of = m_freq;
    ow = m_wave;
    case (m_busy)
      0: if ($countones(k) == 1 && (k & ~p) != 3'b000) begin
           if (k[2]) begin
             m_wave = (m_wave + 1) % 4;
             m_busy = 3;
           end else begin
             m_busy = k[0] ? 1 : 2;
             m_s    = t;
             apply_step();
           end
         end
      1, 2: if (!k[m_busy-1]) m_busy = 0;
            else if (t - m_s >= H && (t - m_s - H) % R == 0) apply_step();
      3: if (!k[2]) m_busy = 0;
      default: m_busy = 0;
    endcase
    m_cfg = (m_freq != of) || (m_wave != ow);
    m_rep = (m_busy == 1 || m_busy == 2) && (t - m_s >= H);
    m_k2 = m_k1;
    m_k1 = {key_mode, key_down, key_up};
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      #1;
      check("wave_sel", int'(wave_sel), m_wave);
      check("freq_word", int'(freq_word), m_freq);
      check("cfg_valid", int'(cfg_valid), int'(m_cfg));
      check("rep_active", int'(rep_active), int'(m_rep));
      pulses += int'(cfg_valid);
    end
  endtask

  task automatic set_keys(logic [2:0] k);
    {key_mode, key_down, key_up} = k;
  endtask

  initial begin
    tbl[0]  = '{3'b100, 3, 4, 2, 100, 1};
    tbl[1]  = '{3'b100, 3, 4, 3, 100, 1};
    tbl[2]  = '{3'b100, 3, 4, 0, 100, 1};
    tbl[3]  = '{3'b100, 3, 4, 1, 100, 1};
    tbl[4]  = '{3'b001, 3, 4, 1, 110, 1};
    tbl[5]  = '{3'b010, 3, 4, 1, 100, 1};
    tbl[6]  = '{3'b010, 3, 4, 1, 90, 1};
    tbl[7]  = '{3'b011, 3, 4, 1, 90, 0};
    tbl[8]  = '{3'b111, 3, 4, 1, 90, 0};
    tbl[9]  = '{3'b101, 5, 4, 1, 90, 0};
    tbl[10] = '{3'b001, 2, 4, 1, 100, 1};

    m_k1 = 3'b111; m_k2 = 3'b111; m_busy = 0; m_s = 0;
    m_wave = 0; m_freq = FI; m_cfg = 0; m_rep = 0;
    clr = 1'b1;
    set_keys(3'b000);

    // Reset state
    tick(3);
    check("rst_wave", int'(wave_sel), 0);
    check("rst_freq", int'(freq_word), 100);
    check("rst_cfg", int'(cfg_valid), 0);
    check("rst_rep", int'(rep_active), 0);
    clr = 1'b0;
    tick(2);

    // key_up held through reset must not step
    key_up = 1'b1; clr = 1'b1;
    tick(2);
    clr = 1'b0; pulses = 0;
    tick(6);
    check("held_thru_rst_freq", int'(freq_word), 100);
    check("held_thru_rst_pulses", pulses, 0);
    key_up = 1'b0;
    tick(4);

    // First mode tap: two-cycle press latency
    key_mode = 1'b1;
    tick(1);
    check("mode_lat_edge_n", int'(cfg_valid), 0);
    tick(1);
    check("mode_lat_edge_n1", int'(cfg_valid), 1);
    check("mode_lat_wave", int'(wave_sel), 1);
    key_mode = 1'b0;
    tick(4);

    // Table of taps and chords
    for (int i = 0; i < 11; i++) begin
      pulses = 0;
      set_keys(tbl[i].keys);
      tick(tbl[i].on_c);
      set_keys(3'b000);
      tick(tbl[i].off_c);
      check($sformatf("tbl%0d_wave", i), int'(wave_sel), tbl[i].wave);
      check($sformatf("tbl%0d_freq", i), int'(freq_word), tbl[i].freq);
      check($sformatf("tbl%0d_pulses", i), pulses, tbl[i].npulse);
    end

    // Hold key_up: steps at S, S+8, S+12, S+16 from 100
    key_up = 1'b1;
    tick(1);
    check("hold_edge_n_cfg", int'(cfg_valid), 0);
    tick(1);
    check("hold_first_freq", int'(freq_word), 110);
    check("hold_first_cfg", int'(cfg_valid), 1);
    for (int i = 1; i <= 38; i++) begin
      tick(1);
      check("hold_seq_freq", int'(freq_word), (i < 8) ? 110 : (i < 12) ? 120 : 130);
      check("hold_seq_cfg", int'(cfg_valid), (i == 8 || i == 12) ? 1 : 0);
      check("hold_seq_rep", int'(rep_active), (i >= 8) ? 1 : 0);
    end
    key_up = 1'b0;
    tick(1);
    check("rel_rep_edge_r", int'(rep_active), 1);
    tick(1);
    check("rel_rep_edge_r1", int'(rep_active), 0);
    check("rel_freq", int'(freq_word), 130);
    tick(3);

    // Walk down to 20, then saturate at FREQ_MIN
    for (int i = 0; i < 11; i++) begin
      key_down = 1'b1; tick(2);
      key_down = 1'b0; tick(3);
    end
    check("down_walk_freq", int'(freq_word), 20);
    pulses = 0;
    key_down = 1'b1; tick(2); key_down = 1'b0; tick(3);
    check("down_sat1_freq", int'(freq_word), 10);
    check("down_sat1_pulses", pulses, 1);
    pulses = 0;
    key_down = 1'b1; tick(2); key_down = 1'b0; tick(3);
    check("down_sat2_freq", int'(freq_word), 10);
    check("down_sat2_pulses", pulses, 0);

    // Lockout: mode pressed during a down hold
    clr = 1'b1; tick(2); clr = 1'b0; tick(2);
    key_down = 1'b1;
    tick(2);
    check("lock_down_freq", int'(freq_word), 90);
    tick(1);
    key_mode = 1'b1; pulses = 0;
    tick(4);
    check("lock_hold_wave", int'(wave_sel), 0);
    key_down = 1'b0;
    tick(5);
    check("lock_rel_wave", int'(wave_sel), 0);
    check("lock_rel_pulses", pulses, 0);
    key_mode = 1'b0; tick(3);
    key_mode = 1'b1; tick(3);
    check("lock_repress_wave", int'(wave_sel), 1);
    key_mode = 1'b0; tick(3);

    // Reset in the middle of a repeat
    key_up = 1'b1;
    tick(14);
    check("mid_rep_active", int'(rep_active), 1);
    clr = 1'b1;
    tick(1);
    check("mid_rst_rep", int'(rep_active), 0);
    check("mid_rst_freq", int'(freq_word), 100);
    clr = 1'b0;
    tick(4);
    check("mid_rst_held_freq", int'(freq_word), 100);
    key_up = 1'b0;
    tick(3);

    // Random keys against the model
    for (int seg = 0; seg < 250; seg++) begin
      int r, dur;
      logic [2:0] k;
      r = $urandom_range(0, 9);
      if (r < 6) k = 3'b001 << $urandom_range(0, 2);
      else       k = 3'($urandom_range(0, 7));
      dur = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 30) : $urandom_range(1, 8);
      set_keys(k);
      if ($urandom_range(0, 39) == 0) begin
        clr = 1'b1; tick(1); clr = 1'b0;
      end
      tick(dur);
    end
    set_keys(3'b000);
    tick(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
